clr_req_ctrl: RTL
=================

CLR_REQ_CTRL -- requirements
Module: clr_req_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): TMO_CYC, 255, max cycles to wait per handshake phase (1..65535); HOLD_CYC, 2, quiesce cycles after completion (0..255).
REQ-002 Ports SHALL be (name, direction, width, meaning): clk  in  1  sole clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 init_n  in  1  synchronous init, active-low.
REQ-005 clr_req  in  1  clear request, sampled each cycle.
REQ-006 clr_ack  out  1  one-cycle request-accepted pulse.
REQ-007 clr_s  out  1  registered clear pulse to source side of reset synchronizer.
REQ-008 clr_in_prog_s  in  1  synchronizer clear-in-progress status.
REQ-009 clr_cmplt_s  in  1  synchronizer clear-complete pulse.
REQ-010 err_clr  in  1  clears error state.
REQ-011 busy  out  1; pend  out  1; done  out  1 (pulse); tmo_err  out  1 (sticky); err_code  out  2.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT_PROG, WAIT_CMPLT, HOLD, ERR.
REQ-013 IDLE with clr_req=1 -> ISSUE next cycle; in ISSUE clr_s=1 and clr_ack=1 for exactly one cycle, then WAIT_PROG with timer loaded to TMO_CYC.
REQ-014 WAIT_PROG: clr_in_prog_s=1 -> WAIT_CMPLT, timer reloaded to TMO_CYC; clr_cmplt_s=1 (missed in_prog) -> HOLD directly; timer reaching 0 -> ERR, err_code=2'b01.
REQ-015 WAIT_CMPLT: clr_cmplt_s=1 -> HOLD, timer loaded to HOLD_CYC; timer reaching 0 -> ERR, err_code=2'b10.
REQ-016 Timer SHALL decrement by 1 per cycle in WAIT_PROG/WAIT_CMPLT/HOLD, never wrap below 0; width = clog2(TMO_CYC+1).
REQ-017 clr_cmplt_s (or clr_in_prog_s) in the same cycle the timer reaches 0 SHALL win over timeout.
REQ-018 HOLD: when timer = 0, done=1 for one cycle; next state ISSUE if pend=1 (pend clears, clr_ack pulses in ISSUE), else IDLE; HOLD_CYC=0 gives done on the HOLD entry cycle.
REQ-019 clr_req=1 in any state except IDLE and ERR SHALL set pend; further requests coalesce (one-deep).
REQ-020 ERR: tmo_err=1, err_code held; clr_req ignored; pend cleared on entry; err_clr=1 -> IDLE, tmo_err=0, err_code=0 next cycle.
REQ-021 busy SHALL be 1 in every state except IDLE; clr_cmplt_s/clr_in_prog_s in IDLE, ISSUE, HOLD, ERR SHALL be ignored.
REQ-022 init_n=0 SHALL force all state and outputs to reset values on the next edge, overriding all other inputs.
REQ-023 All outputs SHALL be registered except busy (decoded from state register).

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=IDLE, timer=0, clr_s=0, clr_ack=0, pend=0, done=0, tmo_err=0, err_code=2'b00, busy=0.
REQ-025 Reset mid-handshake SHALL abandon the clear with no done pulse; release SHALL be synchronous to clk.

Structure
REQ-026 Package clr_req_ctrl_pkg SHALL hold the state enum and err_code constants (ERR_NONE=0, ERR_PROG=1, ERR_CMPLT=2).
REQ-027 One sub-module clr_tmo_cnt (loadable saturating down-counter with zero flag) SHALL implement the timer.

Verification
REQ-028 clr_req pulse in IDLE; in_prog at +3, cmplt at +6 cycles, HOLD_CYC=2 -> clr_s/clr_ack at cycle 1, done at cycle 9, busy 1..9.
REQ-029 No clr_in_prog_s after clr_s, TMO_CYC=4 -> ERR after 4 WAIT_PROG cycles, tmo_err=1, err_code=01; err_clr -> IDLE, outputs 0.
REQ-030 clr_req twice during WAIT_CMPLT -> pend=1; after done, exactly one further clr_s pulse; pend=0.
REQ-031 clr_cmplt_s asserted on the cycle the timer hits 0 -> HOLD, no tmo_err.
REQ-032 rst_n asserted in WAIT_CMPLT, and init_n=0 in HOLD -> all outputs at reset values, no done pulse, clean restart on next clr_req.

Source files
------------

// File: rtl/clr_req_ctrl_pkg.sv
// Shared encodings for the clear-request controller: FSM states, error codes
// and the timer width helper.
package clr_req_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_ISSUE      = 3'd1;
    localparam state_t ST_WAIT_PROG  = 3'd2;
    localparam state_t ST_WAIT_CMPLT = 3'd3;
    localparam state_t ST_HOLD       = 3'd4;
    localparam state_t ST_ERR        = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_PROG  = 2'd1;
    localparam logic [1:0] ERR_CMPLT = 2'd2;

    // Wide enough to hold both the handshake timeout and the quiesce count.
    function automatic int tmr_width(input int tmo_cyc, input int hold_cyc);
        int max_val;
        max_val = (tmo_cyc > hold_cyc) ? tmo_cyc : hold_cyc;
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clr_tmo_cnt.sv
// Loadable saturating down-counter used as the handshake/quiesce timer.
// Load has priority over decrement; the count never wraps below zero.
module clr_tmo_cnt
    import clr_req_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_init_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_zero,
    output logic         o_one
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_init_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == W'(1));

endmodule

// File: rtl/clr_req_ctrl.sv
// Clear-request controller: issues a clear pulse to a reset synchronizer,
// tracks its in-progress/complete handshake with timeouts, then quiesces.
module clr_req_ctrl
    import clr_req_ctrl_pkg::*;
#(
    parameter int TMO_CYC  = 255,
    parameter int HOLD_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_n,
    input  logic       clr_req,
    output logic       clr_ack,
    output logic       clr_s,
    input  logic       clr_in_prog_s,
    input  logic       clr_cmplt_s,
    input  logic       err_clr,
    output logic       busy,
    output logic       pend,
    output logic       done,
    output logic       tmo_err,
    output logic [1:0] err_code
);

    localparam int TMR_W = tmr_width(TMO_CYC, HOLD_CYC);
    localparam logic [TMR_W-1:0] TMO_LD  = TMR_W'(TMO_CYC);
    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC);

    state_t           r_state;
    logic             r_clr_s;
    logic             r_clr_ack;
    logic             r_pend;
    logic             r_done;
    logic             r_tmo_err;
    logic [1:0]       r_err_code;

    state_t           w_nxt_state;
    logic             w_tmr_ld;
    logic [TMR_W-1:0] w_tmr_ld_val;
    logic             w_tmr_dec;
    logic [TMR_W-1:0] w_tmr_cnt;
    logic             w_tmr_zero;
    logic             w_tmr_one;
    logic             w_tmr_expire;
    logic [1:0]       w_err_code;
    logic             w_pend_nxt;
    logic             w_done_nxt;

    clr_tmo_cnt #(
        .W (TMR_W)
    ) u_tmo_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_init_n   (init_n),
        .i_load     (w_tmr_ld),
        .i_load_val (w_tmr_ld_val),
        .i_dec      (w_tmr_dec),
        .o_cnt      (w_tmr_cnt),
        .o_zero     (w_tmr_zero),
        .o_one      (w_tmr_one)
    );

    // The timer "reaches 0" on the edge that decrements it from 1.
    assign w_tmr_expire = w_tmr_one | w_tmr_zero;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_nxt_state  = r_state;
        w_tmr_ld     = 1'b0;
        w_tmr_ld_val = TMO_LD;
        w_err_code   = r_err_code;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) w_nxt_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_nxt_state = ST_WAIT_PROG;
                w_tmr_ld    = 1'b1;
            end
            ST_WAIT_PROG: begin
                // A completion seen here means in-progress was missed.
                if (clr_cmplt_s) begin
                    w_nxt_state  = ST_HOLD;
                    w_tmr_ld     = 1'b1;
                    w_tmr_ld_val = HOLD_LD;
                end else if (clr_in_prog_s) begin
                    w_nxt_state = ST_WAIT_CMPLT;
                    w_tmr_ld    = 1'b1;
                end else if (w_tmr_expire) begin
                    w_nxt_state = ST_ERR;
                    w_err_code  = ERR_PROG;
                end
            end
            ST_WAIT_CMPLT: begin
                if (clr_cmplt_s) begin
                    w_nxt_state  = ST_HOLD;
                    w_tmr_ld     = 1'b1;
                    w_tmr_ld_val = HOLD_LD;
                end else if (w_tmr_expire) begin
                    w_nxt_state = ST_ERR;
                    w_err_code  = ERR_CMPLT;
                end
            end
            ST_HOLD: begin
                if (w_tmr_zero) begin
                    w_nxt_state = (r_pend || clr_req) ? ST_ISSUE : ST_IDLE;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    w_nxt_state = ST_IDLE;
                    w_err_code  = ERR_NONE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_err_code  = ERR_NONE;
            end
        endcase
    end

    assign w_tmr_dec = !w_tmr_ld && ((r_state == ST_WAIT_PROG) ||
                                     (r_state == ST_WAIT_CMPLT) ||
                                     (r_state == ST_HOLD));

    always_comb begin
        w_pend_nxt = r_pend;
        if ((w_nxt_state == ST_ERR) ||
            ((r_state == ST_HOLD) && (w_nxt_state == ST_ISSUE))) begin
            w_pend_nxt = 1'b0;
        end else if (clr_req && (r_state != ST_IDLE) && (r_state != ST_ERR)) begin
            w_pend_nxt = 1'b1;
        end
    end

    // done lands on the cycle HOLD sees a zero count, including HOLD entry
    // when the quiesce count is zero.
    assign w_done_nxt = (w_nxt_state == ST_HOLD) &&
                        (((r_state != ST_HOLD) && (HOLD_CYC == 0)) ||
                         ((r_state == ST_HOLD) && w_tmr_one));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_clr_s    <= 1'b0;
            r_clr_ack  <= 1'b0;
            r_pend     <= 1'b0;
            r_done     <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (!init_n) begin
            r_state    <= ST_IDLE;
            r_clr_s    <= 1'b0;
            r_clr_ack  <= 1'b0;
            r_pend     <= 1'b0;
            r_done     <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_nxt_state;
            r_clr_s    <= (w_nxt_state == ST_ISSUE);
            r_clr_ack  <= (w_nxt_state == ST_ISSUE);
            r_pend     <= w_pend_nxt;
            r_done     <= w_done_nxt;
            r_tmo_err  <= (w_nxt_state == ST_ERR);
            r_err_code <= (w_nxt_state == ST_ERR) ? w_err_code : ERR_NONE;
        end
    end

    assign clr_s    = r_clr_s;
    assign clr_ack  = r_clr_ack;
    assign pend     = r_pend;
    assign done     = r_done;
    assign tmo_err  = r_tmo_err;
    assign err_code = r_err_code;
    assign busy     = (r_state != ST_IDLE);

endmodule
